// File: rtl/bank_pkg.sv
// Shared constants and types for the multi-requester data bank.
package bank_pkg;

    localparam int BANK_W = 128;
    localparam int BANK_A = 9;
    localparam int BANK_N = 3;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Tag/pointer width: enough bits to name any of n requesters, never less than one.
    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_rr.sv
// Single-grant arbiter, fixed priority or round-robin; the rotating pointer lives here.
module arb_rr
    import bank_pkg::*;
#(
    parameter int N  = BANK_N,
    parameter int RR = int'(ARB_RR),
    parameter int TW = tag_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grnt,
    output logic [TW-1:0] idx
);

    localparam bit RR_EN = (RR == int'(ARB_RR));

    logic [TW-1:0] ptr_r;
    logic [N-1:0]  grnt_s;
    logic [TW-1:0] idx_s;
    logic [TW-1:0] cidx_s;
    logic          found_s;
    int            start_s;
    int            cand_s;

    // Scan requesters from the start point (pointer in round-robin, 0 in fixed mode) and take the first one asserted.
    always_comb begin
        grnt_s  = '0;
        idx_s   = '0;
        found_s = 1'b0;
        cand_s  = 0;
        cidx_s  = '0;
        start_s = RR_EN ? int'(ptr_r) : 0;
        for (int k = 0; k < N; k++) begin
            cand_s = start_s + k;
            if (cand_s >= N) begin
                cand_s = cand_s - N;
            end else begin
                cand_s = cand_s;
            end
            cidx_s = cand_s[TW-1:0];
            if (!found_s && req[cidx_s]) begin
                found_s        = 1'b1;
                grnt_s[cidx_s] = 1'b1;
                idx_s          = cidx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Advance the pointer past the winner, wrapping N-1 to 0; hold when idle or in fixed mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (RR_EN && found_s) begin
            ptr_r <= (idx_s == TW'(N - 1)) ? '0 : idx_s + TW'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign grnt = grnt_s;
    assign idx  = idx_s;

endmodule

// File: rtl/bram_be.sv
// Simple dual-port byte-enabled RAM, registered read-first output.
module bram_be #(
    parameter int W = 128,
    parameter int A = 9
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           we,
    input  logic [A-1:0]   waddr,
    input  logic [W-1:0]   wdata,
    input  logic [W/8-1:0] wmask,
    input  logic           re,
    input  logic [A-1:0]   raddr,
    output logic [W-1:0]   rdata
);

    localparam int NB    = W / 8;
    localparam int DEPTH = 1 << A;

    logic [W-1:0] mem_r [DEPTH];
    logic [W-1:0] rdata_r;

    // Byte-lane writes; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (wmask[b]) begin
                    mem_r[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Output register: samples the pre-write word on a collision and holds when not reading.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= '0;
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/bank_rr.sv
// N-requester data bank: one arbitrated read port, one arbitrated byte-masked write port.
module bank_rr
    import bank_pkg::*;
#(
    parameter int W  = BANK_W,
    parameter int A  = BANK_A,
    parameter int N  = BANK_N,
    parameter int RR = int'(ARB_RR),
    parameter int TW = tag_width(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     rd_req,
    input  logic [N*A-1:0]   rd_addr,
    output logic [N-1:0]     rd_grnt,
    output logic             rd_valid,
    output logic [TW-1:0]    rd_tag,
    output logic [W-1:0]     rd_word,
    input  logic [N-1:0]     wr_req,
    input  logic [N*A-1:0]   wr_addr,
    input  logic [N*W-1:0]   wr_word,
    input  logic [N*W/8-1:0] wr_mask,
    output logic [N-1:0]     wr_grnt
);

    localparam int NB = W / 8;

    logic [N-1:0]  rd_grnt_s;
    logic [N-1:0]  wr_grnt_s;
    logic [TW-1:0] rd_idx_s;
    logic [TW-1:0] wr_idx_s;
    logic          rd_en_s;
    logic          wr_en_s;
    logic [A-1:0]  rd_addr_sel_s;
    logic [A-1:0]  wr_addr_sel_s;
    logic [W-1:0]  wr_word_sel_s;
    logic [NB-1:0] wr_mask_sel_s;
    logic          rd_valid_r;
    logic [TW-1:0] rd_tag_r;

    arb_rr #(.N(N), .RR(RR), .TW(TW)) u_rd_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (rd_req),
        .grnt (rd_grnt_s),
        .idx  (rd_idx_s)
    );

    arb_rr #(.N(N), .RR(RR), .TW(TW)) u_wr_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (wr_req),
        .grnt (wr_grnt_s),
        .idx  (wr_idx_s)
    );

    // Route the winning requester's address/data/mask to the RAM; the enables gate idle cycles.
    always_comb begin
        rd_en_s       = |rd_grnt_s;
        wr_en_s       = |wr_grnt_s;
        rd_addr_sel_s = rd_addr[int'(rd_idx_s)*A +: A];
        wr_addr_sel_s = wr_addr[int'(wr_idx_s)*A +: A];
        wr_word_sel_s = wr_word[int'(wr_idx_s)*W +: W];
        wr_mask_sel_s = wr_mask[int'(wr_idx_s)*NB +: NB];
    end

    bram_be #(.W(W), .A(A)) u_bram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en_s),
        .waddr (wr_addr_sel_s),
        .wdata (wr_word_sel_s),
        .wmask (wr_mask_sel_s),
        .re    (rd_en_s),
        .raddr (rd_addr_sel_s),
        .rdata (rd_word)
    );

    // Read-response qualifiers: valid pulses one cycle after a grant, tag holds while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_r <= 1'b0;
            rd_tag_r   <= '0;
        end else if (rd_en_s) begin
            rd_valid_r <= 1'b1;
            rd_tag_r   <= rd_idx_s;
        end else begin
            rd_valid_r <= 1'b0;
            rd_tag_r   <= rd_tag_r;
        end
    end

    assign rd_grnt  = rd_grnt_s;
    assign wr_grnt  = wr_grnt_s;
    assign rd_valid = rd_valid_r;
    assign rd_tag   = rd_tag_r;

endmodule
